ysyx_23060191_gpr: RTL and testbench
====================================

YSYX_23060191_GPR -- requirements
Module: ysyx_23060191_gpr

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL: rstn  in  1  reset, synchronous, active-low.
REQ-003 SHALL: wb_valid  in  1  writeback strobe from the WBU stage.
REQ-004 SHALL: wb_rd  in  5  writeback destination register index.
REQ-005 SHALL: wb_data  in  CPU_WIDTH  writeback value.
REQ-006 SHALL: rs1_addr, rs2_addr  in  5 each  decode-stage source register indices.
REQ-007 SHALL: rs1_en, rs2_en  in  1 each  source operand is actually used.
REQ-008 SHALL: rs1_data, rs2_data  out  CPU_WIDTH each  source operand values.
REQ-009 SHALL: iss_valid  in  1  decode requests issue of an instruction.
REQ-010 SHALL: iss_rd  in  5  destination index of the issuing instruction (0 means no write).
REQ-011 SHALL: stall  out  1  issue refused this cycle.
REQ-012 SHALL: dbg_addr  in  5  debug/difftest read index.
REQ-013 SHALL: dbg_data  out  CPU_WIDTH  debug read value (architectural, no bypass).
REQ-014 SHALL: sb_err  out  1  sticky scoreboard underflow/overflow flag.

Function
REQ-015 SHALL: hold 31 architectural registers x1..x31 of CPU_WIDTH bits; x0 reads 0 on every port and is never written.
REQ-016 SHALL: write wb_data into x[wb_rd] at the rising edge when wb_valid=1 and wb_rd!=0.
REQ-017 SHALL: read rs1_data/rs2_data combinationally; when wb_valid=1, wb_rd==rsN_addr and rsN_addr!=0, return wb_data (same-cycle bypass), else the stored value.
REQ-018 SHALL: keep a 2-bit pending counter cnt[r] per register r=1..31; cnt[0] is constant 0.
REQ-019 SHALL: define accept = iss_valid & ~stall; on accept with iss_rd!=0, increment cnt[iss_rd].
REQ-020 SHALL: on wb_valid with wb_rd!=0, decrement cnt[wb_rd]; if accept increments and wb decrements the same register in the same cycle, the counter remains unchanged.
REQ-021 SHALL: define busy(r) = cnt[r]!=0 and not (wb_valid & wb_rd==r & cnt[r]==1), so that a completing last write is bypassed rather than stalled.
REQ-022 SHALL: drive stall = iss_valid & ((rs1_en & busy(rs1_addr)) | (rs2_en & busy(rs2_addr)) | (iss_rd!=0 & cnt[iss_rd]==3 & ~(wb_valid & wb_rd==iss_rd))); stall is 0 when iss_valid=0.
REQ-023 SHALL: treat a writeback to a register with cnt==0 as an underflow: still perform the write, hold cnt at 0, and set sb_err.
REQ-024 SHALL: keep sb_err set until reset.
REQ-025 SHALL: make dbg_data show the stored value of x[dbg_addr] (0 for x0), unaffected by the bypass.

Reset
REQ-026 SHALL: at a rising edge with rstn=0, clear x1..x31, all cnt and sb_err to 0, regardless of wb_valid or iss_valid.
REQ-027 SHALL: after reset, present rs1_data=rs2_data=dbg_data=0 and stall=0 until the first write or issue.
REQ-028 SHALL: discard in-flight pending counts if rstn is asserted mid-operation; no writeback from before reset is tracked afterwards.

Structure
REQ-029 SHALL: take CPU_WIDTH and a GPR_NUM=32 constant from the shared defines file; no local redefinition.
REQ-030 SHALL: implement the counter array in one sub-module ysyx_23060191_scoreboard (cnt, busy, overflow and underflow logic), with register storage and bypass in the top module.

Verification
REQ-031 SHALL: write x5=0xDEADBEEF (wb_valid=1), then read rs1_addr=5 on the next cycle -> rs1_data=0xDEADBEEF; write to x0=0x1234 -> rs2_addr=0 reads 0.
REQ-032 SHALL: wb_valid=1, wb_rd=7, wb_data=0xA5A5A5A5 with rs2_addr=7 in the same cycle -> rs2_data=0xA5A5A5A5 combinationally, while dbg_addr=7 shows the old value.
REQ-033 SHALL: issue iss_rd=3, then next cycle issue with rs1_addr=3, rs1_en=1 -> stall=1; on the cycle wb_rd=3 arrives (cnt=1) -> stall=0 and rs1_data=wb_data.
REQ-034 SHALL: issue iss_rd=9 three times without writeback -> fourth issue to rd=9 stalls; the same fourth issue in a cycle with wb_rd=9 -> accepted, cnt stays 3.
REQ-035 SHALL: wb_valid=1, wb_rd=4 with cnt[4]=0 -> x4 written, sb_err=1 and stays 1; rstn=0 for one edge -> sb_err=0, x4=0.
REQ-036 SHALL: rs1_en=0 with rs1_addr pointing at a busy register -> stall=0.

Source files
------------

// File: rtl/ysyx_23060191_gpr_pkg.sv
// Shared CPU-wide constants and types for the register file and scoreboard.
package ysyx_23060191_gpr_pkg;
    localparam int unsigned CPU_WIDTH = 32;
    localparam int unsigned GPR_NUM   = 32;
    localparam int unsigned REG_AW    = $clog2(GPR_NUM);

    typedef logic [REG_AW-1:0]    reg_idx_t;
    typedef logic [CPU_WIDTH-1:0] word_t;
endpackage

// File: rtl/ysyx_23060191_scoreboard.sv
// Per-register pending-write counters; issues stall on RAW hazards and counter saturation.
module ysyx_23060191_scoreboard
    import ysyx_23060191_gpr_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd,
    input  logic     iss_valid,
    input  reg_idx_t iss_rd,
    input  reg_idx_t rs1_addr,
    input  logic     rs1_en,
    input  reg_idx_t rs2_addr,
    input  logic     rs2_en,
    output logic     stall,
    output logic     sb_err
);
    logic [1:0] cnt_q [GPR_NUM];
    logic       err_q;
    logic       rd_full, accept, inc, dec;

    // A register whose last outstanding write completes this cycle is bypassed, not busy.
    function automatic logic busy_f(input logic [1:0] c, input logic hit);
        return (c != 2'd0) && !(hit && (c == 2'd1));
    endfunction

    always_comb begin
        rd_full = (iss_rd != '0) && (cnt_q[iss_rd] == 2'd3) && !(wb_valid && (wb_rd == iss_rd));
        stall   = iss_valid &&
                  ((rs1_en && busy_f(cnt_q[rs1_addr], wb_valid && (wb_rd == rs1_addr))) ||
                   (rs2_en && busy_f(cnt_q[rs2_addr], wb_valid && (wb_rd == rs2_addr))) ||
                   rd_full);
        accept  = iss_valid && !stall;
        inc     = accept && (iss_rd != '0);
        dec     = wb_valid && (wb_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < GPR_NUM; i++) cnt_q[i] <= 2'd0;
            err_q <= 1'b0;
        end else if (inc && dec && (iss_rd == wb_rd)) begin
            // Net change is zero; a writeback with nothing pending is still an underflow.
            if (cnt_q[wb_rd] == 2'd0) err_q <= 1'b1;
        end else begin
            if (inc) begin
                if (cnt_q[iss_rd] == 2'd3) err_q <= 1'b1;
                else cnt_q[iss_rd] <= cnt_q[iss_rd] + 2'd1;
            end
            if (dec) begin
                if (cnt_q[wb_rd] == 2'd0) err_q <= 1'b1;
                else cnt_q[wb_rd] <= cnt_q[wb_rd] - 2'd1;
            end
        end
    end

    assign sb_err = err_q;
endmodule

// File: rtl/ysyx_23060191_gpr.sv
// General-purpose register file with same-cycle writeback bypass and issue scoreboard.
module ysyx_23060191_gpr
    import ysyx_23060191_gpr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [CPU_WIDTH-1:0] wb_data,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic [REG_AW-1:0]    rs2_addr,
    input  logic                 rs1_en,
    input  logic                 rs2_en,
    output logic [CPU_WIDTH-1:0] rs1_data,
    output logic [CPU_WIDTH-1:0] rs2_data,
    input  logic                 iss_valid,
    input  logic [REG_AW-1:0]    iss_rd,
    output logic                 stall,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [CPU_WIDTH-1:0] dbg_data,
    output logic                 sb_err
);
    word_t regs_q [GPR_NUM];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < GPR_NUM; i++) regs_q[i] <= '0;
        end else if (wb_valid && (wb_rd != '0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    function automatic word_t read_port(input reg_idx_t a, input word_t stored);
        if (a == '0) return '0;
        if (wb_valid && (wb_rd == a)) return wb_data;
        return stored;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr, regs_q[rs1_addr]);
        rs2_data = read_port(rs2_addr, regs_q[rs2_addr]);
        dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    end

    ysyx_23060191_scoreboard u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1_addr  (rs1_addr),
        .rs1_en    (rs1_en),
        .rs2_addr  (rs2_addr),
        .rs2_en    (rs2_en),
        .stall     (stall),
        .sb_err    (sb_err)
    );
endmodule

// File: tb/tb_ysyx_23060191_gpr.sv
// Randomized and directed bench for the GPR file against an array-based reference model.
module tb_ysyx_23060191_gpr;
    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_en, rs2_en;
    logic [31:0] rs1_data, rs2_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        stall;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        sb_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;

    always #5 clk = ~clk;

    ysyx_23060191_gpr dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_en    (rs1_en),
        .rs2_en    (rs2_en),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .stall     (stall),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .sb_err    (sb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic bit m_busy(input int r);
        return (m_cnt[r] != 0) && !(wb_valid && (int'(wb_rd) == r) && (m_cnt[r] == 1));
    endfunction

    function automatic bit m_stall();
        bit haz;
        haz = (rs1_en && m_busy(int'(rs1_addr))) || (rs2_en && m_busy(int'(rs2_addr))) ||
              ((iss_rd != 0) && (m_cnt[iss_rd] == 3) && !(wb_valid && (wb_rd == iss_rd)));
        return iss_valid && haz;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && (wb_rd == a)) return wb_data;
        return m_reg[a];
    endfunction

    task automatic idle();
        rstn = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_en = 1'b0; rs2_en = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; dbg_addr = '0;
    endtask

    task automatic cmp_model();
        check_eq("rs1_data", rs1_data, m_read(rs1_addr));
        check_eq("rs2_data", rs2_data, m_read(rs2_addr));
        check_eq("stall", {31'b0, stall}, {31'b0, m_stall()});
        check_eq("dbg_data", dbg_data, (dbg_addr == 0) ? 32'h0 : m_reg[dbg_addr]);
        check_eq("sb_err", {31'b0, sb_err}, {31'b0, m_err});
    endtask

    // Inputs are already settled when called; compares, clocks, then advances the model.
    task automatic tick(input bit chk);
        bit acc;
        int n;
        if (chk) cmp_model();
        acc = iss_valid && !m_stall();
        @(posedge clk);
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                n = m_cnt[r];
                if (acc && (int'(iss_rd) == r)) n = n + 1;
                if (wb_valid && (int'(wb_rd) == r)) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    n = n - 1;
                    m_reg[r] = wb_data;
                end
                if (n < 0) n = 0;
                if (n > 3) begin n = 3; m_err = 1'b1; end
                m_cnt[r] = n;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); rstn = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4; iss_valid = 1'b1; iss_rd = 5'd9;
        tick(0);
        idle();
        #1;
    endtask

    initial begin
        idle();
        do_reset();
        check_eq("rst_rs1", rs1_data, 32'h0);
        check_eq("rst_stall", {31'b0, stall}, 32'h0);

        // Write x5, read next cycle; write x0 reads back 0.
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; #1; tick(1);
        idle(); rs1_addr = 5'd5; #1;
        check_eq("x5_read", rs1_data, 32'hDEADBEEF);
        tick(1);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; #1; tick(1);
        idle(); rs2_addr = 5'd0; #1;
        check_eq("x0_read", rs2_data, 32'h0);
        tick(1);
        do_reset();

        // RAW stall on x3, released by the completing writeback with bypass.
        iss_valid = 1'b1; iss_rd = 5'd3; #1; tick(1);
        idle(); iss_valid = 1'b1; rs1_addr = 5'd3; rs1_en = 1'b1; #1;
        check_eq("raw_stall", {31'b0, stall}, 32'h1);
        tick(1);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11112222; #1;
        check_eq("raw_release", {31'b0, stall}, 32'h0);
        check_eq("raw_bypass", rs1_data, 32'h11112222);
        tick(1);

        // Counter saturation on x9.
        for (int k = 0; k < 3; k++) begin
            idle(); iss_valid = 1'b1; iss_rd = 5'd9; #1;
            check_eq("sat_issue", {31'b0, stall}, 32'h0);
            tick(1);
        end
        idle(); iss_valid = 1'b1; iss_rd = 5'd9; #1;
        check_eq("sat_stall", {31'b0, stall}, 32'h1);
        tick(1);
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; #1;
        check_eq("sat_wb_accept", {31'b0, stall}, 32'h0);
        tick(1);
        idle(); iss_valid = 1'b1; iss_rd = 5'd9; #1;
        check_eq("sat_still3", {31'b0, stall}, 32'h1);

        // Disabled source ignores a busy register.
        idle(); iss_valid = 1'b1; rs1_addr = 5'd9; rs1_en = 1'b0; #1;
        check_eq("en0_nostall", {31'b0, stall}, 32'h0);
        rs1_en = 1'b1; #1;
        check_eq("en1_stall", {31'b0, stall}, 32'h1);
        tick(1);

        // Bypass vs debug port on x7.
        idle(); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77; #1; tick(1);
        idle(); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
        rs2_addr = 5'd7; dbg_addr = 5'd7; #1;
        check_eq("byp_rs2", rs2_data, 32'hA5A5A5A5);
        check_eq("byp_dbg_old", dbg_data, 32'h77);
        tick(1);

        // Underflow is sticky until reset.
        idle(); wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44; #1; tick(1);
        idle(); dbg_addr = 5'd4; #1;
        check_eq("uf_err", {31'b0, sb_err}, 32'h1);
        check_eq("uf_write", dbg_data, 32'h44);
        tick(1); tick(1);
        check_eq("uf_sticky", {31'b0, sb_err}, 32'h1);
        do_reset();
        dbg_addr = 5'd4; iss_valid = 1'b1; rs1_addr = 5'd9; rs1_en = 1'b1; #1;
        check_eq("rst_err", {31'b0, sb_err}, 32'h0);
        check_eq("rst_x4", dbg_data, 32'h0);
        check_eq("rst_cnt_flush", {31'b0, stall}, 32'h0);
        tick(1);

        // Random traffic; writebacks only target registers with pending issues.
        for (int c = 0; c < 600; c++) begin
            int r;
            idle();
            rstn      = ($urandom_range(0, 149) != 0);
            iss_valid = $urandom_range(0, 1) != 0;
            iss_rd    = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            rs1_en    = $urandom_range(0, 1) != 0;
            rs2_en    = $urandom_range(0, 1) != 0;
            dbg_addr  = 5'($urandom_range(0, 31));
            r = $urandom_range(1, 7);
            if ((m_cnt[r] > 0) && ($urandom_range(0, 2) != 0)) begin
                wb_valid = 1'b1; wb_rd = 5'(r); wb_data = $urandom;
            end
            #1;
            tick(1);
        end

        idle();
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a); #1;
            check_eq("final_dbg", dbg_data, (a == 0) ? 32'h0 : m_reg[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
